// File: rtl/swap_perm.sv
// swap_perm: registered CH-lane permutation (pass/pair-swap/reverse/rotate) behind a valid/ready stage with a 16-bit transfer counter
module swap_perm #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int CW    = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] din,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [CW-1:0]       rot,
  output logic [CH*WIDTH-1:0] dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         xfer_cnt
);
  logic [CH*WIDTH-1:0] dout_q, dout_d, perm;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         xfer_cnt_q, xfer_cnt_d;
  logic [CW-1:0]       idx;
  logic                acc, con;
  assign in_ready  = !out_valid_q || out_ready;
  assign acc       = in_valid && in_ready;
  assign con       = out_valid_q && out_ready;
  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;
  always_comb begin
    perm = '0;
    idx  = '0;
    for (int i = 0; i < CH; i++) begin
      idx = mode == 2'd0 ? CW'(i) :
            mode == 2'd1 ? CW'(i) ^ CW'(1) :
            mode == 2'd2 ? CW'(CH - 1 - i) :
                           CW'(i) + rot;
      perm[i*WIDTH +: WIDTH] = din[idx*WIDTH +: WIDTH];
    end
  end
  always_comb begin
    dout_d      = acc ? perm : dout_q;
    out_valid_d = acc ? 1'b1 : con ? 1'b0 : out_valid_q;
    xfer_cnt_d  = xfer_cnt_q + 16'(con);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end
endmodule
